prog_sequencer: RTL
===================

# prog_sequencer

Program sequencer for the 9-bit accumulator CPU. It owns the program counter and the run/stall/halt state machine, and it gates architectural writes through `ExecEn`. It handles the `Start`/`Done` handshake with the testbench and stretches load instructions to the data-memory latency. It sits between instruction ROM addressing and the instruction decoder, consuming the decoder's `Branch`, `ReadMem` and `Halt` signals.

## Interface
Parameters:
- `PC_W`, default 10: program counter width; instruction ROM depth is 2^PC_W.
- `START_PC`, default 0: address loaded on reset and on every accepted `Start`.
- `MEM_LAT`, default 1: data-memory read latency in cycles. Legal range 1..4.

Ports:
- `Clk`, input, 1: single clock; all state changes on the rising edge.
- `Reset`, input, 1: synchronous, active-low reset.
- `Start`, input, 1: run request, sampled only in IDLE or HALTED.
- `Branch`, input, 1: decoder says the current instruction is a branch.
- `Taken`, input, 1: branch condition true. Ignored unless `Branch`=1.
- `Target`, input, PC_W: branch target from the LUT.
- `ReadMem`, input, 1: current instruction is a load.
- `Halt`, input, 1: current instruction is the halt encoding.
- `PC`, output, PC_W: registered instruction address.
- `ExecEn`, output, 1: enables R0, general-register and memory writes this cycle.
- `Done`, output, 1: program finished; registered.
- `CycleCount`, output, 16: number of execution cycles in the last or current run.

## Operation
States: IDLE, RUN, MEMWAIT, HALTED. A 2-bit wait counter `wcnt` supports MEMWAIT.

- **Reset** (`Reset`=0 at a clock edge): state=IDLE, PC=START_PC, Done=0, CycleCount=0, wcnt=0. Reset has priority over every other input in every state, including MEMWAIT.
- **IDLE**
  - ExecEn=0. PC holds.
  - `Start`=1 → RUN, PC=START_PC, CycleCount=0.
- **RUN**: one instruction per cycle at `PC`. Priority order:
  1. `Halt`=1 → HALTED, Done=1, PC holds, ExecEn=0. `Branch` and `ReadMem` are ignored.
  2. `ReadMem`=1 and MEM_LAT>1 → MEMWAIT, wcnt=MEM_LAT-2, ExecEn=0, PC holds.
  3. `Branch`=1 and `Taken`=1 → PC=Target, ExecEn=1.
  4. Otherwise → PC=PC+1, ExecEn=1. PC is modulo 2^PC_W, so 2^PC_W-1 wraps to 0.
  - With MEM_LAT=1, a load completes in its single RUN cycle with ExecEn=1.
- **MEMWAIT**: the instruction inputs are still those of the held PC.
  - wcnt≠0: wcnt decrements; ExecEn=0; PC holds.
  - wcnt=0: ExecEn=1; PC=PC+1 (wrapping); state returns to RUN.
- **HALTED**
  - Done=1. ExecEn=0. PC holds.
  - `Start`=1 → RUN, PC=START_PC, Done=0, CycleCount=0.
- **Ignored inputs**: `Start` is ignored in RUN and MEMWAIT. `Branch`, `Taken`, `ReadMem` and `Halt` are ignored in IDLE and HALTED.
- **CycleCount**
  - Increments on every cycle spent in RUN or MEMWAIT, including the halt cycle.
  - Saturates at 0xFFFF.
  - Holds in IDLE and HALTED.

## Timing
- `ExecEn` is combinational from state, wcnt, `Halt` and `ReadMem`. All other outputs are registered.
- `PC` updates on the edge that ends the executing cycle. A taken branch presents `Target` on `PC` in the next cycle, with zero bubbles.
- A load occupies exactly MEM_LAT cycles at the same `PC`. ExecEn is 1 only in the last of those cycles.
- `Done` rises on the edge after the halt cycle and stays high until reset or an accepted `Start`.
- First instruction: `Start` sampled in cycle n puts START_PC on `PC` with state RUN in cycle n+1.
- Reset, all outputs: PC=START_PC, ExecEn=0, Done=0, CycleCount=0.

## Test plan
- **Reset**: hold `Reset`=0 for 2 cycles with `Start`=1 → PC=0, ExecEn=0, Done=0, CycleCount=0, state IDLE, and `Start` has no effect.
- **Straight-line run**: pulse `Start`; PC=0..4 are non-branch instructions, `Halt`=1 at PC=5 → PC steps 0,1,2,3,4,5; ExecEn=1 for 5 cycles and 0 on the halt cycle; Done=1 next cycle; CycleCount=6.
- **Branch**: `Branch`=1 at PC=3.
  - `Taken`=1, `Target`=40 → next PC=40.
  - `Taken`=0 → next PC=4.
  - `Halt`=1 together with a taken branch → HALTED, PC stays 3.
- **Load stall**: MEM_LAT=3, `ReadMem`=1 at PC=2 → PC=2 for 3 cycles with ExecEn 0,0,1, then PC=3.
  - Repeat with MEM_LAT=1 → PC=3 after one cycle, with ExecEn=1.
- **Wrap and saturation**: at PC=1023 with a non-branch → PC=0; force more than 65535 run cycles → CycleCount stays 0xFFFF.
- **Reset and restart**:
  - `Reset`=0 during MEMWAIT → IDLE, PC=0, and no ExecEn pulse follows.
  - From HALTED, `Start`=1 → Done=0 and PC=0 next cycle.

Source files
------------

// File: rtl/prog_sequencer_if.sv
// Decoder/testbench side of the program sequencer:
// run handshake, decoded instruction flags and sequencer outputs.
interface prog_sequencer_if #(
   parameter int PC_W = 10
);
   logic            Start;
   logic            Branch;
   logic            Taken;
   logic [PC_W-1:0] Target;
   logic            ReadMem;
   logic            Halt;
   logic [PC_W-1:0] PC;
   logic            ExecEn;
   logic            Done;
   logic [15:0]     CycleCount;

   modport master (
      output Start, Branch, Taken, Target, ReadMem, Halt,
      input  PC, ExecEn, Done, CycleCount
   );

   modport slave (
      input  Start, Branch, Taken, Target, ReadMem, Halt,
      output PC, ExecEn, Done, CycleCount
   );
endinterface

// File: rtl/prog_sequencer.sv
// Program sequencer for the 9-bit accumulator CPU: PC, run/stall/halt
// control, write gating via ExecEn and load stretching to memory latency.
module prog_sequencer #(
   parameter int              PC_W     = 10,
   parameter logic [PC_W-1:0] START_PC = '0,
   parameter int              MEM_LAT  = 1
) (
   input logic              Clk,
   input logic              Reset,
   prog_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      MEMWAIT,
      HALTED
   } state_t;

   localparam bit STALL = (MEM_LAT > 1);
   localparam logic [1:0] WINIT =
      STALL ? 2'(MEM_LAT - 2) : 2'd0;

   state_t          state;
   logic [1:0]      wcnt;
   logic [PC_W-1:0] pc;
   logic            done;
   logic [15:0]     cc;
   logic            exec;
   logic [15:0]     cc_nxt;

   assign cc_nxt = (cc == 16'hFFFF) ? cc : cc + 16'd1;

   // Halt and a stretched load both suppress writes in RUN.
   always_comb begin
      exec = 1'b0;
      unique case (state)
         RUN:     exec = !bus.Halt && !(bus.ReadMem && STALL);
         MEMWAIT: exec = (wcnt == 2'd0);
         default: exec = 1'b0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state <= IDLE;
         pc    <= START_PC;
         done  <= 1'b0;
         cc    <= 16'd0;
         wcnt  <= 2'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.Start) begin
                  state <= RUN;
                  pc    <= START_PC;
                  cc    <= 16'd0;
               end
            end
            RUN: begin
               cc <= cc_nxt;
               if (bus.Halt) begin
                  state <= HALTED;
                  done  <= 1'b1;
               end else if (bus.ReadMem && STALL) begin
                  state <= MEMWAIT;
                  wcnt  <= WINIT;
               end else if (bus.Branch && bus.Taken) begin
                  pc <= bus.Target;
               end else begin
                  pc <= pc + 1'b1;
               end
            end
            MEMWAIT: begin
               cc <= cc_nxt;
               if (wcnt != 2'd0) begin
                  wcnt <= wcnt - 2'd1;
               end else begin
                  pc    <= pc + 1'b1;
                  state <= RUN;
               end
            end
            HALTED: begin
               if (bus.Start) begin
                  state <= RUN;
                  pc    <= START_PC;
                  done  <= 1'b0;
                  cc    <= 16'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.PC         = pc;
   assign bus.ExecEn     = exec;
   assign bus.Done       = done;
   assign bus.CycleCount = cc;

endmodule
